// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: load/store width
// encodings (also used by the core's decode and controller), FSM state
// encoding and the latched request record.
package dmem_responder_pkg;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Width of the wait-state counter; holds LATENCY-1 for LATENCY up to 15
    localparam int unsigned CNT_W = 4;

    // Request fields captured at acceptance (address is kept separately
    // because only its low AW+2 bits are meaningful)
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } dmem_req_t;

    // True when funct3 names a width that exists for the given direction
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage load/store bus between the core (master) and the
// data-memory responder (slave), including the stall returned to hazard logic.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables and data
// replication, load extraction with sign/zero extension, and detection of
// misaligned accesses and illegal funct3 values. Purely combinational.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic       misal;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    // Flag halves on odd addresses, words off a word boundary, and bad funct3
    always_comb begin
        misal = 1'b0;
        case (funct3_i)
            F3_H, F3_HU: misal = addr_lo_i[0];
            F3_W:        misal = (addr_lo_i != 2'b00);
            default:     misal = 1'b0;
        endcase
        err_o = misal || !f3_legal(we_i, funct3_i);
    end

    // Store lanes: data is replicated across lanes, enables pick the target
    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        if (we_i && !err_o) begin
            case (funct3_i)
                F3_B: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_H: begin
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                F3_W: begin
                    be_o    = '1;
                    wdata_o = wdata_i;
                end
                default: begin
                    be_o    = '0;
                    wdata_o = '0;
                end
            endcase
        end
    end

    // Select the addressed byte and half of the stored word
    always_comb begin
        byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    // Load result with extension; zero for stores and faulting accesses
    always_comb begin
        rdata_o = '0;
        if (!we_i && !err_o) begin
            case (funct3_i)
                F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
                F3_BU:   rdata_o = {24'h000000, byte_sel};
                F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
                F3_HU:   rdata_o = {16'h0000, half_sel};
                F3_W:    rdata_o = rword_i;
                default: rdata_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the memory stage. Accepts one load/store when idle,
// waits LATENCY cycles while stalling the pipeline, then commits the store or
// reads the load in the single response cycle. Word-organised array with
// byte-lane writes; upper address bits wrap.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned AW      = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    dmem_responder_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic [AW+1:0]    addr_q, addr_d;

    logic [31:0] mem_q [0:(1 << AW) - 1];

    logic [AW-1:0] word_idx;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wdata_al;
    logic [31:0]   rdata_ext;
    logic          acc_err;
    logic          in_resp;
    logic          unused_addr_hi;

    // Address bits above the array are deliberately ignored (wrap-around)
    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    assign word_idx = addr_q[AW+1:2];
    assign rword    = mem_q[word_idx];
    assign in_resp  = (state_q == RESP);

    dmem_lane_align u_align (
        .we_i      (req_q.we),
        .funct3_i  (req_q.funct3),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (req_q.wdata),
        .rword_i   (rword),
        .be_o      (be),
        .wdata_o   (wdata_al),
        .rdata_o   (rdata_ext),
        .err_o     (acc_err)
    );

    // Next-state logic: accept in IDLE, count wait states, respond once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d.we     = bus.req_we;
                    req_d.funct3 = bus.req_funct3;
                    req_d.wdata  = bus.req_wdata;
                    addr_d       = bus.req_addr[AW+1:0];
                    cnt_d        = CNT_LOAD;
                    state_d      = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // req_valid here is still the instruction being answered
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and request latch with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    // Store commit in the response cycle; reset in that cycle cancels it
    always_ff @(posedge clk) begin
        if (!rst && in_resp) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wdata_al[8*i +: 8];
                end
            end
        end
    end

    // Bus outputs: ready when idle, one-cycle response, stall until response
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = in_resp;
        bus.resp_err   = in_resp && acc_err;
        bus.resp_rdata = in_resp ? rdata_ext : '0;
        bus.stall      = ((state_q == IDLE) && bus.req_valid) || (state_q == WAIT);
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave at the far end of the core's memory-stage load/store interface.
- Accepts one load or store per handshake, inserts LATENCY cycles of wait states, and returns byte/half/word data with RISC-V sign/zero extension.
- Drives a stall back to the hazard logic so the memory-stage instruction is held until its response cycle.
- Word-organised internal array; stores use byte lanes.

Parameters:
- AW, 10: word-address width; the array holds 2^AW 32-bit words.
- LATENCY, 2: cycles from request acceptance to resp_valid. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  memory-stage instruction is a load or store
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_ready  out  1  request accepted this cycle
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid
- stall  out  1  hold the fetch, decode, execute and memory stages

Behaviour:
- Reset, synchronous and active-high: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, request latch cleared. Array contents are not reset.
- FSM IDLE:
  - req_ready=1 when state is IDLE.
  - An acceptance (req_valid & req_ready) at cycle T latches we, funct3, addr and wdata, and loads the counter with LATENCY-1.
  - Next state is RESP if LATENCY==1, else WAIT.
- FSM WAIT: decrement the counter; go to RESP when the counter reaches 1.
- FSM RESP:
  - resp_valid=1 for exactly one cycle, at T+LATENCY.
  - Next state is always IDLE.
  - req_valid in RESP is the same held instruction and is ignored (no re-acceptance).
- stall = (IDLE & req_valid) | WAIT, so stall is high for cycles T..T+LATENCY-1 and low in RESP.
- Back-to-back requests: the next request can be accepted at T+LATENCY+1 at the earliest.
- Commit point: the store write and the load read both happen in the RESP cycle, using the latched fields.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(AW+2) bytes.
- Store byte lanes, no read-modify-write visible externally:
  - sb writes lane addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0},{addr[1],1} with wdata[15:0].
  - sw writes all 4 lanes.
- Load extraction:
  - b and h: sign-extend the selected byte/half.
  - bu and hu: zero-extend.
  - w: the whole word.
- Error conditions:
  - h/hu/sh with addr[0]=1.
  - w/sw with addr[1:0]!=0.
  - funct3 not in {000,001,010,100,101}.
  - Stores with funct3 100 or 101 are illegal.
- Error response: no array write, resp_rdata=0, resp_err=1, same latency.
- Reset mid-operation (WAIT): the transaction is dropped, the pending store is never written, resp_valid stays 0, stall drops next cycle.
- Reset has priority over all events in the same cycle.

Decomposition:
- Shared package: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and FSM state encoding (IDLE, WAIT, RESP). The core's controller and decode reuse the funct3 constants.
- One natural sub-module, dmem_lane_align:
  - combinational byte-enable and store-data shift generation;
  - load extraction and sign/zero extension;
  - misalignment and illegal-funct3 detection.
- The FSM, counter and array stay in dmem_responder.

Test Plan:
- LATENCY=2: sw addr 0x10 data 0xDEADBEEF at T -> stall=1 at T,T+1, resp_valid at T+2 with resp_err=0. Then lw 0x10 -> resp_rdata=0xDEADBEEF at its T+2.
- Byte extension: sb 0x13 data 0x80, then lb 0x13 -> 0xFFFFFF80 and lbu 0x13 -> 0x00000080. Word 0x10 reads 0x80ADBEEF.
- Half extension: sh 0x12 data 0x8001, then lh 0x12 -> 0xFFFF8001 and lhu 0x12 -> 0x00008001. Other lanes unchanged.
- Misaligned: lw 0x11 -> resp_err=1, rdata=0. sh 0x15 -> resp_err=1 and word 0x14 unchanged.
- Reset in WAIT: sw 0x20 data 0x12345678, rst in cycle T+1 -> no resp_valid, stall=0 at T+2, and a later lw 0x20 returns the old contents.
- LATENCY=1 and wrap:
  - req_valid held -> exactly one resp_valid per instruction, with stall=1 only in cycle T;
  - sw at addr 2^(AW+2)+4 is readable at addr 4.
